// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
//   state_t : memory-wait FSM states
//   rule_t  : which priority rule drives the control outputs this cycle
//   pick_rule : strict-priority selection, first match wins
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    ERROR
  } state_t;

  typedef enum logic [2:0] {
    NONE,
    MEM,
    BR,
    LU,
    JMP
  } rule_t;

  function automatic rule_t pick_rule(input logic mem_busy, input logic br,
                                      input logic lu, input logic jmp);
    if (mem_busy) return MEM;
    if (br)       return BR;
    if (lu)       return LU;
    if (jmp)      return JMP;
    return NONE;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the hazard controller.
//   master : pipeline side, drives hazard sources, receives hold/flush/status
//   slave  : controller side
// Parameter CNT_W sets the width of the stall/flush event counters.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             MemRead_EX;
  logic [4:0]       rt_EX;
  logic [4:0]       rs_ID;
  logic [4:0]       rt_ID;
  logic             Branch_EX;
  logic             BranchTaken_EX;
  logic             Jump_ID;
  logic             MemRead_MEM;
  logic             MemWrite_MEM;
  logic             dmem_ready;

  logic             hold_PC;
  logic             hold_IFID;
  logic             hold_IDEX;
  logic             hold_EXMEM;
  logic             flush_IFID;
  logic             flush_IDEX;
  logic             flush_MEMWB;
  logic             mem_error;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output MemRead_EX, rt_EX, rs_ID, rt_ID, Branch_EX, BranchTaken_EX,
           Jump_ID, MemRead_MEM, MemWrite_MEM, dmem_ready,
    input  hold_PC, hold_IFID, hold_IDEX, hold_EXMEM,
           flush_IFID, flush_IDEX, flush_MEMWB, mem_error,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  MemRead_EX, rt_EX, rs_ID, rt_ID, Branch_EX, BranchTaken_EX,
           Jump_ID, MemRead_MEM, MemWrite_MEM, dmem_ready,
    output hold_PC, hold_IFID, hold_IDEX, hold_EXMEM,
           flush_IFID, flush_IDEX, flush_MEMWB, mem_error,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter.
//   clk   : clock
//   clr   : asynchronous active-high clear
//   inc   : count one event at the next edge
//   count : current value, sticks at all-ones
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller for the five-stage core.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : hazard sources in (load-use, branch, jump, dmem access),
//                hold/flush controls, sticky mem_error and event counters out
// Control outputs are combinational from the FSM state and current inputs.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  bus
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  logic              mem_busy;
  logic              br;
  logic              lu;
  logic              jmp;
  rule_t             rule;
  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              stall_inc;
  logic              flush_inc;

  logic hold_pc, hold_ifid, hold_idex, hold_exmem;
  logic flush_ifid, flush_idex, flush_memwb;

  always_comb begin
    mem_busy = (bus.MemRead_MEM | bus.MemWrite_MEM) & ~bus.dmem_ready;
    br       = bus.Branch_EX & bus.BranchTaken_EX;
    // A load into $0 never produces a usable value, so it cannot hazard.
    lu       = bus.MemRead_EX & (bus.rt_EX != 5'd0) &
               ((bus.rt_EX == bus.rs_ID) | (bus.rt_EX == bus.rt_ID));
    jmp      = bus.Jump_ID;
    rule     = pick_rule(mem_busy, br, lu, jmp);
  end

  always_comb begin
    hold_pc     = 1'b0;
    hold_ifid   = 1'b0;
    hold_idex   = 1'b0;
    hold_exmem  = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_memwb = 1'b0;
    if (!reset) begin
      if (state == ERROR) begin
        // Freeze the whole pipe until reset; only MEM/WB gets bubbles.
        {hold_pc, hold_ifid, hold_idex, hold_exmem, flush_memwb} = '1;
      end else begin
        case (rule)
          MEM: {hold_pc, hold_ifid, hold_idex, hold_exmem, flush_memwb} = '1;
          BR:  {flush_ifid, flush_idex} = '1;
          LU:  {hold_pc, hold_ifid, flush_idex} = '1;
          JMP: flush_ifid = 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign bus.hold_PC     = hold_pc;
  assign bus.hold_IFID   = hold_ifid;
  assign bus.hold_IDEX   = hold_idex;
  assign bus.hold_EXMEM  = hold_exmem;
  assign bus.flush_IFID  = flush_ifid;
  assign bus.flush_IDEX  = flush_idex;
  assign bus.flush_MEMWB = flush_memwb;
  assign bus.mem_error   = (state == ERROR);

  // wait_cnt holds the number of busy cycles already completed; when it
  // reads TIMEOUT-1 during a busy cycle, this cycle is the TIMEOUT-th one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      if (state != ERROR) begin
        wait_cnt <= mem_busy ? wait_cnt + WAIT_W'(1) : '0;
      end
      case (state)
        RUN: begin
          if (mem_busy) state <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (!mem_busy) begin
            state <= RUN;
          end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
            state <= ERROR;
          end
        end
        ERROR: ;
        default: state <= RUN;
      endcase
    end
  end

  assign stall_inc = !reset && (state != ERROR) && ((rule == MEM) || (rule == LU));
  assign flush_inc = !reset && (state != ERROR) && ((rule == BR) || (rule == JMP));

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (reset),
    .inc   (stall_inc),
    .count (bus.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr   (reset),
    .inc   (flush_inc),
    .count (bus.flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed test of hazard_ctrl with TIMEOUT = 4 and CNT_W = 4.
module tb_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  hazard_ctrl_if #(.CNT_W(4)) bus ();

  hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed controls: {hold_PC, hold_IFID, hold_IDEX, hold_EXMEM,
  //                   flush_IFID, flush_IDEX, flush_MEMWB}
  logic [6:0] ctrl;
  assign ctrl = {bus.hold_PC, bus.hold_IFID, bus.hold_IDEX, bus.hold_EXMEM,
                 bus.flush_IFID, bus.flush_IDEX, bus.flush_MEMWB};

  function automatic logic [6:0] exp_ctrl(input rule_t r);
    case (r)
      MEM:     return 7'b1111_001;
      BR:      return 7'b0000_110;
      LU:      return 7'b1100_010;
      JMP:     return 7'b0000_100;
      default: return 7'b0000_000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s value=%0h", tag, got);
    end
  endtask

  task automatic clear_inputs();
    bus.MemRead_EX     = 1'b0;
    bus.rt_EX          = 5'd0;
    bus.rs_ID          = 5'd0;
    bus.rt_ID          = 5'd0;
    bus.Branch_EX      = 1'b0;
    bus.BranchTaken_EX = 1'b0;
    bus.Jump_ID        = 1'b0;
    bus.MemRead_MEM    = 1'b0;
    bus.MemWrite_MEM   = 1'b0;
    bus.dmem_ready     = 1'b0;
  endtask

  // Check controls mid-cycle, then let the cycle commit.
  task automatic step(input string tag, input rule_t r);
    @(negedge clk);
    chk(tag, 32'(ctrl), 32'(exp_ctrl(r)));
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Hazard sources active while in reset: nothing may assert.
    bus.MemRead_MEM = 1'b1;
    bus.MemRead_EX  = 1'b1;
    bus.rt_EX       = 5'd8;
    bus.rs_ID       = 5'd8;
    #1;
    chk("rst_ctrl", 32'(ctrl), 32'h0);
    chk("rst_err", 32'(bus.mem_error), 32'h0);
    chk("rst_stall", 32'(bus.stall_cnt), 32'h0);
    chk("rst_flush", 32'(bus.flush_cnt), 32'h0);
    clear_inputs();
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Load-use on rs, then a load to $0.
    bus.MemRead_EX = 1'b1; bus.rt_EX = 5'd8; bus.rs_ID = 5'd8; bus.rt_ID = 5'd2;
    step("lu", LU);
    clear_inputs();
    step("lu_after", NONE);
    chk("lu_stall", 32'(bus.stall_cnt), 32'd1);
    bus.MemRead_EX = 1'b1; bus.rt_EX = 5'd0; bus.rs_ID = 5'd0; bus.rt_ID = 5'd0;
    step("ld_r0", NONE);
    chk("ld_r0_stall", 32'(bus.stall_cnt), 32'd1);
    chk("ld_r0_flush", 32'(bus.flush_cnt), 32'd0);

    // Taken branch beats load-use; untaken branch does not.
    do_reset();
    chk("reset_stall", 32'(bus.stall_cnt), 32'd0);
    bus.Branch_EX = 1'b1; bus.BranchTaken_EX = 1'b1;
    bus.MemRead_EX = 1'b1; bus.rt_EX = 5'd5; bus.rt_ID = 5'd5; bus.rs_ID = 5'd1;
    step("br_lu", BR);
    clear_inputs();
    chk("br_flush", 32'(bus.flush_cnt), 32'd1);
    chk("br_stall", 32'(bus.stall_cnt), 32'd0);
    bus.Branch_EX = 1'b1; bus.BranchTaken_EX = 1'b0;
    bus.MemRead_EX = 1'b1; bus.rt_EX = 5'd5; bus.rt_ID = 5'd5;
    step("nt_lu", LU);
    clear_inputs();
    chk("nt_stall", 32'(bus.stall_cnt), 32'd1);
    chk("nt_flush", 32'(bus.flush_cnt), 32'd1);

    // Three-cycle memory wait, then a single-cycle wait on a store.
    do_reset();
    bus.MemRead_MEM = 1'b1; bus.dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("wait3", MEM);
    bus.dmem_ready = 1'b1;
    step("wait3_rdy", NONE);
    clear_inputs();
    chk("wait3_stall", 32'(bus.stall_cnt), 32'd3);
    chk("wait3_err", 32'(bus.mem_error), 32'd0);
    bus.MemWrite_MEM = 1'b1; bus.dmem_ready = 1'b0;
    step("wait1", MEM);
    bus.dmem_ready = 1'b1;
    step("wait1_rdy", NONE);
    clear_inputs();
    step("wait1_run", NONE);
    chk("wait1_stall", 32'(bus.stall_cnt), 32'd4);

    // Busy with taken branch: branch counted once after the wait.
    do_reset();
    bus.MemRead_MEM = 1'b1; bus.dmem_ready = 1'b0;
    bus.Branch_EX = 1'b1; bus.BranchTaken_EX = 1'b1;
    step("busy_br0", MEM);
    step("busy_br1", MEM);
    bus.dmem_ready = 1'b1;
    step("busy_br_rdy", BR);
    clear_inputs();
    step("busy_br_done", NONE);
    chk("busy_br_flush", 32'(bus.flush_cnt), 32'd1);
    chk("busy_br_stall", 32'(bus.stall_cnt), 32'd2);

    // Timeout after four busy cycles, sticky ERROR, async reset recovery.
    do_reset();
    bus.MemRead_MEM = 1'b1; bus.dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) step("to_busy", MEM);
    chk("to_err", 32'(bus.mem_error), 32'd1);
    bus.dmem_ready = 1'b1;
    bus.Branch_EX = 1'b1; bus.BranchTaken_EX = 1'b1;
    step("err_hold", MEM);
    chk("err_sticky", 32'(bus.mem_error), 32'd1);
    chk("err_stall", 32'(bus.stall_cnt), 32'd4);
    chk("err_flush", 32'(bus.flush_cnt), 32'd0);
    reset = 1'b1;
    #1;
    chk("err_rst_ctrl", 32'(ctrl), 32'h0);
    chk("err_rst_err", 32'(bus.mem_error), 32'd0);
    chk("err_rst_stall", 32'(bus.stall_cnt), 32'd0);
    clear_inputs();
    reset = 1'b0;
    step("post_err", NONE);
    chk("post_err_flag", 32'(bus.mem_error), 32'd0);

    // Load-use with jump in ID: stall first, flush on the next cycle.
    do_reset();
    bus.MemRead_EX = 1'b1; bus.rt_EX = 5'd3; bus.rs_ID = 5'd3; bus.Jump_ID = 1'b1;
    step("lu_jmp0", LU);
    bus.MemRead_EX = 1'b0; bus.rt_EX = 5'd0;
    step("lu_jmp1", JMP);
    clear_inputs();
    chk("lu_jmp_stall", 32'(bus.stall_cnt), 32'd1);
    chk("lu_jmp_flush", 32'(bus.flush_cnt), 32'd1);

    // Saturation of the 4-bit stall counter.
    do_reset();
    bus.MemRead_EX = 1'b1; bus.rt_EX = 5'd7; bus.rt_ID = 5'd7;
    for (int i = 0; i < 20; i++) begin
      step("sat_lu", LU);
      if (i == 14) chk("sat_at15", 32'(bus.stall_cnt), 32'd15);
    end
    clear_inputs();
    chk("sat_hold", 32'(bus.stall_cnt), 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage MIPS core. It drives the hold and flush inputs of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It resolves load-use hazards, taken branches resolved in EX, jumps decoded in ID, and data-memory wait states. A small FSM tracks memory waits and raises a sticky error on timeout. Saturating counters record stall and flush cycles for performance debug.

## Interface
- TIMEOUT, 16: consecutive memory-busy cycles before entering ERROR (>= 2)
- CNT_W, 32: width of stall/flush counters
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- MemRead_EX  in  1  instruction in EX is a load
- rt_EX  in  5  load destination register in EX
- rs_ID, rt_ID  in  5 each  source registers of instruction in ID
- Branch_EX  in  1  instruction in EX is a branch
- BranchTaken_EX  in  1  branch condition true in EX
- Jump_ID  in  1  instruction in ID is j/jal/jr/jalr
- MemRead_MEM, MemWrite_MEM  in  1 each  MEM stage accesses data memory
- dmem_ready  in  1  data memory completes access this cycle
- hold_PC, hold_IFID, hold_IDEX, hold_EXMEM  out  1 each  freeze register
- flush_IFID, flush_IDEX, flush_MEMWB  out  1 each  load bubble at next edge
- mem_error  out  1  sticky memory timeout flag
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

## Operation
- mem_busy = (MemRead_MEM | MemWrite_MEM) & ~dmem_ready.
- br = Branch_EX & BranchTaken_EX.
- lu = MemRead_EX & (rt_EX != 0) & (rt_EX == rs_ID | rt_EX == rt_ID).
- jmp = Jump_ID.
- Control outputs are Mealy and combinational from state plus inputs. Strict priority, first match wins:
  - mem_busy: all four holds = 1, flush_MEMWB = 1.
  - br: flush_IFID = flush_IDEX = 1.
  - lu: hold_PC = hold_IFID = 1, flush_IDEX = 1.
  - jmp: flush_IFID = 1.
  - otherwise all outputs = 0.
- FSM states:
  - RUN: mem_busy -> MEM_WAIT, else stay.
  - MEM_WAIT: ~mem_busy -> RUN. If busy has lasted TIMEOUT consecutive cycles (counted from the first busy cycle in RUN) -> ERROR.
  - ERROR: terminal until reset. All four holds = 1, flush_MEMWB = 1, all other flushes = 0, mem_error = 1.
- Wait counter: clears whenever mem_busy = 0; increments each busy cycle.
- stall_cnt: +1 per cycle in which hold_PC = 1 due to mem_busy or lu. Not incremented in ERROR.
- flush_cnt: +1 per cycle in which the br or jmp rule wins. Not incremented in ERROR.
- Both counters saturate at all-ones and never wrap.

## Timing
- Zero-cycle latency: outputs reflect inputs in the same cycle and are consumed by pipeline registers at the next posedge clk.
- Reset values: state RUN, wait counter 0, stall_cnt 0, flush_cnt 0, mem_error 0. While reset = 1, every hold/flush output = 0.
- Reset mid-wait or in ERROR: the FSM returns to RUN immediately (asynchronous) and counters clear.
- br with lu in the same cycle: only the br rule applies. No stall; flush_cnt +1, stall_cnt unchanged.
- mem_busy with br: hold everything. EX is frozen, so br re-evaluates after the wait and flush_cnt counts it exactly once.
- lu with jmp: stall first. The jump stays in ID, then flush_IFID asserts on the following cycle.
- Load to $0: never a hazard.
- Single-cycle busy (ready on the next cycle): one hold cycle, stall_cnt +1, FSM path RUN -> MEM_WAIT -> RUN.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - the FSM state enum (RUN, MEM_WAIT, ERROR);
  - the priority-rule encoding (NONE, MEM, BR, LU, JMP) used by the bench for checking.
- One natural sub-module, sat_counter: parameterised width, synchronous increment, asynchronous active-high clear, saturation at all-ones. It is instantiated twice.

## Test plan
- lw $8 in EX (rt_EX = 8, MemRead_EX = 1), ID has rs_ID = 8 -> hold_PC = hold_IFID = flush_IDEX = 1 for exactly 1 cycle; stall_cnt = 1. Repeat with rt_EX = 0 -> no outputs asserted.
- Branch_EX = 1, BranchTaken_EX = 1 together with lu true -> flush_IFID = flush_IDEX = 1, holds = 0; flush_cnt = 1, stall_cnt = 0.
- MemRead_MEM = 1, dmem_ready low for 3 cycles -> 3 cycles of all holds plus flush_MEMWB; stall_cnt = 3; FSM returns to RUN after ready.
- dmem_ready held low with TIMEOUT = 4 -> ERROR entered after the 4th busy cycle; mem_error = 1 and holds stay asserted; asynchronous reset pulse -> RUN, all counters 0.
- lu and Jump_ID together -> cycle 1 stall only, cycle 2 flush_IFID = 1; counters end at stall_cnt = 1, flush_cnt = 1.
- CNT_W = 4 with 20 consecutive lu cycles -> stall_cnt saturates at 15 and holds there.
